// File: rtl/duck_controller.sv
// Duck Hunt duck controller: flight FSM, shot handling and sprite addressing.
// Optional DUCK_JITTER_EN adds an LFSR that randomises vertical direction on X bounces.
module duck_controller #(
  parameter int X_MAX         = 575,
  parameter int GROUND_Y      = 352,
  parameter int SPEED         = 2,
  parameter int ESCAPE_FRAMES = 600,
  parameter int HIT_FRAMES    = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        launch,
  input  logic        trigger,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  cursor_x,
  input  logic [9:0]  cursor_y,
  output logic        is_duck,
  output logic [15:0] duck_addr,
  output logic [2:0]  duck_state,
  output logic [1:0]  shots_left,
  output logic        hit,
  output logic        escaped
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLY    = 3'd1,
    HIT    = 3'd2,
    FALL   = 3'd3,
    ESCAPE = 3'd4
  } state_t;

  localparam logic signed [10:0] SPD     = 11'(SPEED);
  localparam logic signed [10:0] XMAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] GND_S   = 11'(GROUND_Y);
  localparam logic signed [10:0] DROP    = 11'sd4;
  localparam logic [15:0]        ESC_LIM = 16'(ESCAPE_FRAMES);
  localparam logic [15:0]        HIT_LIM = 16'(HIT_FRAMES - 1);

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                               input logic signed [10:0] hi);
    if (v < 11'sd0)  return 11'sd0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic logic in_box(input logic signed [10:0] px, input logic signed [10:0] py,
                                  input logic signed [10:0] bx, input logic signed [10:0] by);
    return (px >= bx) && (px <= bx + 11'sd63) && (py >= by) && (py <= by + 11'sd63);
  endfunction

  function automatic logic [1:0] flap_next(input logic [1:0] f);
    return (f == 2'd2) ? 2'd0 : f + 2'd1;
  endfunction

  state_t state_q, state_d;

  logic frame_sync_p0, frame_sync_p1, frame_sync_p2;
  logic trig_sync_p0, trig_sync_p1, trig_sync_p2;
  logic frame_tick, shot;

  logic signed [10:0] x_q, y_q, vx_q, vy_q;
  logic [1:0]         shots_q;
  logic [15:0]        frame_cnt_q, hit_cnt_q;
  logic [2:0]         flap_div_q;
  logic [1:0]         flap_q;
  logic               hit_q, esc_q;

  logic signed [10:0] nx, ny, nx_c, ny_c, fy, ey, fall_y, esc_y;
  logic               bounce_x, bounce_y, fall_done, esc_done;
  logic               shot_ok, hit_now;
  logic [2:0]         sprite_frame;
  logic [5:0]         ox, oy, col;

  // Two-flop synchronizers plus one edge-detect flop for each async input
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_sync_p0 <= 1'b0;
      frame_sync_p1 <= 1'b0;
      frame_sync_p2 <= 1'b0;
      trig_sync_p0  <= 1'b0;
      trig_sync_p1  <= 1'b0;
      trig_sync_p2  <= 1'b0;
    end else begin
      frame_sync_p0 <= frame_clk;
      frame_sync_p1 <= frame_sync_p0;
      frame_sync_p2 <= frame_sync_p1;
      trig_sync_p0  <= trigger;
      trig_sync_p1  <= trig_sync_p0;
      trig_sync_p2  <= trig_sync_p1;
    end
  end

  assign frame_tick = frame_sync_p1 & ~frame_sync_p2;
  assign shot       = trig_sync_p1 & ~trig_sync_p2;

`ifdef DUCK_JITTER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  always_comb begin
    nx        = x_q + vx_q;
    ny        = y_q + vy_q;
    nx_c      = clamp(nx, XMAX_S);
    ny_c      = clamp(ny, GND_S);
    bounce_x  = (nx < 11'sd0) || (nx > XMAX_S);
    bounce_y  = (ny < 11'sd0) || (ny > GND_S);
    fy        = y_q + DROP;
    ey        = y_q - DROP;
    fall_y    = clamp(fy, GND_S);
    esc_y     = clamp(ey, GND_S);
    fall_done = (fy >= GND_S);
    esc_done  = (ey <= 11'sd0);
    shot_ok   = (state_q == FLY) && shot && (shots_q != 2'd0);
    // Hit test always sees the position before this cycle's motion
    hit_now   = shot_ok && in_box($signed({1'b0, cursor_x}), $signed({1'b0, cursor_y}), x_q, y_q);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = FLY;
      FLY: begin
        if (hit_now)
          state_d = HIT;
        else if ((shot_ok && shots_q == 2'd1) || frame_cnt_q >= ESC_LIM)
          state_d = ESCAPE;
      end
      HIT:     if (frame_tick && hit_cnt_q == HIT_LIM) state_d = FALL;
      FALL:    if (frame_tick && fall_done) state_d = IDLE;
      ESCAPE:  if (frame_tick && esc_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    duck_state   = state_q;
    sprite_frame = 3'd0;
    case (state_q)
      FLY, ESCAPE: sprite_frame = {1'b0, flap_q};
      HIT:         sprite_frame = 3'd3;
      FALL:        sprite_frame = 3'd4;
      default:     sprite_frame = 3'd0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x_q         <= 11'sd0;
      y_q         <= GND_S;
      vx_q        <= SPD;
      vy_q        <= -SPD;
      shots_q     <= 2'd0;
      frame_cnt_q <= 16'd0;
      hit_cnt_q   <= 16'd0;
      flap_div_q  <= 3'd0;
      flap_q      <= 2'd0;
      hit_q       <= 1'b0;
      esc_q       <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      esc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            x_q         <= 11'sd0;
            y_q         <= GND_S;
            vx_q        <= SPD;
            vy_q        <= -SPD;
            shots_q     <= 2'd3;
            frame_cnt_q <= 16'd0;
            hit_cnt_q   <= 16'd0;
            flap_div_q  <= 3'd0;
            flap_q      <= 2'd0;
          end
        end
        FLY: begin
          if (shot_ok) shots_q <= shots_q - 2'd1;
          if (hit_now) begin
            hit_q     <= 1'b1;
            hit_cnt_q <= 16'd0;
          end else if (frame_tick) begin
            x_q         <= nx_c;
            y_q         <= ny_c;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            flap_div_q  <= flap_div_q + 3'd1;
            if (flap_div_q == 3'd7) flap_q <= flap_next(flap_q);
            if (bounce_x) vx_q <= -vx_q;
`ifdef DUCK_JITTER_EN
            if (bounce_x)      vy_q <= lfsr_q[0] ? -SPD : SPD;
            else if (bounce_y) vy_q <= -vy_q;
`else
            if (bounce_y) vy_q <= -vy_q;
`endif
          end
        end
        HIT:  if (frame_tick) hit_cnt_q <= hit_cnt_q + 16'd1;
        FALL: if (frame_tick) y_q <= fall_y;
        ESCAPE: begin
          if (frame_tick) begin
            y_q        <= esc_y;
            flap_div_q <= flap_div_q + 3'd1;
            if (flap_div_q == 3'd7) flap_q <= flap_next(flap_q);
            if (esc_done) esc_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shots_left = shots_q;
  assign hit        = hit_q;
  assign escaped    = esc_q;

  // Sprite is 64x64, mirrored horizontally when flying left
  always_comb begin
    is_duck   = (state_q != IDLE) &&
                in_box($signed({1'b0, DrawX}), $signed({1'b0, DrawY}), x_q, y_q);
    ox        = DrawX[5:0] - x_q[5:0];
    oy        = DrawY[5:0] - y_q[5:0];
    col       = vx_q[10] ? ~ox : ox;
    duck_addr = is_duck ? {1'b0, sprite_frame, oy, col} : 16'd0;
  end

endmodule

// File: tb/tb_duck_controller.sv
// Directed self-checking bench for duck_controller (default build, jitter disabled).
module tb_duck_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        launch = 1'b0;
  logic        trigger = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, cursor_x = '0, cursor_y = '0;
  logic        is_duck;
  logic [15:0] duck_addr;
  logic [2:0]  duck_state;
  logic [1:0]  shots_left;
  logic        hit, escaped;

  int n_vec = 0;
  int n_miss = 0;
  int hit_seen = 0;
  int esc_seen = 0;

  duck_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .launch(launch), .trigger(trigger),
    .DrawX(DrawX), .DrawY(DrawY), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .is_duck(is_duck), .duck_addr(duck_addr), .duck_state(duck_state),
    .shots_left(shots_left), .hit(hit), .escaped(escaped)
  );

  always #5 Clk = ~Clk;

  // Sampled once per cycle, so a pulse wider than one cycle counts more than once
  always @(negedge Clk) begin
    if (hit)     hit_seen <= hit_seen + 1;
    if (escaped) esc_seen <= esc_seen + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic launch_duck();
    @(negedge Clk);
    launch = 1'b1;
    @(negedge Clk);
    launch = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic shoot();
    trigger = 1'b1;
    repeat (4) @(negedge Clk);
    trigger = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic shoot_tick();
    trigger   = 1'b1;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    trigger   = 1'b0;
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // Duck box top-left is at (x,y) iff (x,y) is inside while (x-1,y) and (x,y-1) are not
  task automatic probe_pos(input string tag, input int x, input int y);
    logic [2:0] obs;
    @(negedge Clk);
    DrawX = 10'(x);     DrawY = 10'(y);     #1 obs[2] = is_duck;
    DrawX = 10'(x - 1);                     #1 obs[1] = is_duck;
    DrawX = 10'(x);     DrawY = 10'(y - 1); #1 obs[0] = is_duck;
    check_val(tag, {29'd0, obs}, 32'd4);
  endtask

  task automatic probe_addr(input string tag, input int x, input int y, input int exp);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1 check_val(tag, {16'd0, duck_addr}, exp);
  endtask

  initial begin
    int h0, e0;

    // Reset state
    DrawX = 10'd0;
    DrawY = 10'd352;
    repeat (3) @(negedge Clk);
    check_val("rst_state", duck_state, 0);
    check_val("rst_shots", shots_left, 0);
    check_val("rst_hit", hit, 0);
    check_val("rst_esc", escaped, 0);
    check_val("rst_is_duck", is_duck, 0);
    Reset = 1'b1;
    @(negedge Clk);
    check_val("idle_is_duck", is_duck, 0);

    // Launch and straight flight
    launch_duck();
    check_val("launch_state", duck_state, 1);
    check_val("launch_shots", shots_left, 3);
    probe_pos("launch_pos", 0, 352);
    tick(10);
    check_val("fly10_state", duck_state, 1);
    probe_pos("fly10_pos", 20, 332);
    probe_addr("fly10_addr", 20, 332, 4096);

    // Asynchronous reset mid-flight
    h0 = hit_seen;
    e0 = esc_seen;
    @(negedge Clk);
    DrawX = 10'd20;
    DrawY = 10'd332;
    #1 check_val("pre_rst_is_duck", is_duck, 1);
    #1 Reset = 1'b0;
    #1;
    check_val("async_rst_state", duck_state, 0);
    check_val("async_rst_shots", shots_left, 0);
    check_val("async_rst_is_duck", is_duck, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_val("async_rst_no_hit", hit_seen - h0, 0);
    check_val("async_rst_no_esc", esc_seen - e0, 0);

    // Hit, hold, fall, back to idle
    do_reset();
    launch_duck();
    tick(5);
    cursor_x = 10'd30;
    cursor_y = 10'd360;
    h0 = hit_seen;
    e0 = esc_seen;
    shoot();
    check_val("hit_pulse", hit_seen - h0, 1);
    check_val("hit_shots", shots_left, 2);
    check_val("hit_state", duck_state, 2);
    probe_pos("hit_pos", 10, 342);
    tick(29);
    check_val("hit29_state", duck_state, 2);
    probe_pos("hit29_frozen", 10, 342);
    tick(1);
    check_val("fall_state", duck_state, 3);
    probe_addr("fall_addr", 10, 342, 16384);
    tick(2);
    check_val("fall2_state", duck_state, 3);
    probe_pos("fall2_pos", 10, 350);
    tick(1);
    check_val("fall_idle_state", duck_state, 0);
    probe_addr("fall_idle_addr", 10, 352, 0);
    check_val("fall_hit_total", hit_seen - h0, 1);
    check_val("fall_no_esc", esc_seen - e0, 0);

    // Three misses, escape, ignored fourth shot
    do_reset();
    launch_duck();
    cursor_x = 10'd639;
    cursor_y = 10'd0;
    h0 = hit_seen;
    e0 = esc_seen;
    shoot();
    check_val("miss1_shots", shots_left, 2);
    shoot();
    check_val("miss2_shots", shots_left, 1);
    shoot();
    check_val("miss3_shots", shots_left, 0);
    check_val("miss3_state", duck_state, 4);
    tick(87);
    check_val("esc87_state", duck_state, 4);
    probe_pos("esc87_pos", 0, 4);
    probe_addr("esc87_addr", 0, 4, 4096);
    check_val("esc87_no_pulse", esc_seen - e0, 0);
    tick(1);
    check_val("esc_idle_state", duck_state, 0);
    check_val("esc_pulse", esc_seen - e0, 1);
    shoot();
    check_val("shot4_shots", shots_left, 0);
    check_val("shot4_state", duck_state, 0);
    check_val("miss_no_hit", hit_seen - h0, 0);

    // Right-edge bounce and mirrored sprite
    do_reset();
    launch_duck();
    tick(287);
    probe_pos("edge_pre_pos", 574, 220);
    probe_addr("edge_pre_addr", 574, 220, 8192);
    tick(1);
    check_val("edge_state", duck_state, 1);
    probe_pos("edge_pos", 575, 222);
    probe_addr("edge_addr_mirror", 575, 222, 63);
    probe_addr("edge_addr_inner", 637, 223, 65);

    // Shot and frame tick in the same cycle
    do_reset();
    launch_duck();
    tick(5);
    cursor_x = 10'd10;
    cursor_y = 10'd360;
    h0 = hit_seen;
    shoot_tick();
    check_val("same_cyc_hit", hit_seen - h0, 1);
    check_val("same_cyc_state", duck_state, 2);
    check_val("same_cyc_shots", shots_left, 2);
    probe_pos("same_cyc_pos", 10, 342);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/duck_controller.md
DUCK_CONTROLLER -- requirements
Module: duck_controller

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- X_MAX, 575, maximum duck left-edge X
- GROUND_Y, 352, duck top-edge Y at the grass line
- SPEED, 2, pixels per frame tick on each axis
- ESCAPE_FRAMES, 600, frame ticks before forced escape
- HIT_FRAMES, 30, frame ticks the hit pose is held

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1, system clock
- Reset, in, 1, reset
- frame_clk, in, 1, VGA vertical sync (asynchronous to the logic)
- launch, in, 1, start-duck pulse
- trigger, in, 1, gun button (level)
- DrawX, in, 10, current pixel X
- DrawY, in, 10, current pixel Y
- cursor_x, in, 10, cursor X
- cursor_y, in, 10, cursor Y
- is_duck, out, 1, pixel inside the duck box
- duck_addr, out, 16, duck sprite ROM address
- duck_state, out, 3, FSM state code
- shots_left, out, 2, remaining shots
- hit, out, 1, one-cycle pulse on a hit
- escaped, out, 1, one-cycle pulse when the duck leaves

REQ-003 The clock and reset SHALL follow the already-decided rule: one clock, Clk; reset is asynchronous and active-low, Reset.

Function
REQ-004 frame_clk SHALL be synchronized with two flops.
REQ-005 A frame tick SHALL be a one-cycle pulse on the synchronized rising edge of frame_clk.
REQ-006 trigger SHALL be synchronized the same way; a shot SHALL be its one-cycle rising-edge pulse.
REQ-007 The FSM states and duck_state codes SHALL be IDLE=0, FLY=1, HIT=2, FALL=3, ESCAPE=4.
REQ-008 IDLE: on launch, the block SHALL set x=0, y=GROUND_Y, vx=+SPEED, vy=-SPEED, shots_left=3, frame counter=0, and enter FLY the next cycle.
REQ-009 launch SHALL be ignored in every state other than IDLE.
REQ-010 FLY, X motion: on each frame tick the block SHALL apply x+=vx; a result >X_MAX SHALL clamp to X_MAX and negate vx; a result <0 SHALL clamp to 0 and negate vx.
REQ-011 FLY, Y motion: y SHALL update the same way with bounds 0 and GROUND_Y.
REQ-012 Arithmetic SHALL use 11-bit signed intermediates so no underflow wraps.
REQ-013 FLY, shot with shots_left>0: the block SHALL decrement shots_left.
REQ-014 The shot SHALL be a hit if x<=cursor_x<=x+63 and y<=cursor_y<=y+63; on a hit the block SHALL pulse hit and enter HIT.
REQ-015 A shot SHALL be ignored when shots_left==0.
REQ-016 FLY: on a miss that leaves shots_left==0, or when the frame counter reaches ESCAPE_FRAMES, the block SHALL enter ESCAPE.
REQ-017 A shot and a frame tick in the same cycle: the hit test SHALL use the pre-update position, and a hit SHALL suppress that tick's motion.
REQ-018 HIT: position SHALL be frozen; after HIT_FRAMES frame ticks the block SHALL enter FALL.
REQ-019 FALL: on each frame tick the block SHALL apply y+=4, saturating at GROUND_Y; on reaching GROUND_Y it SHALL enter IDLE.
REQ-020 ESCAPE: on each frame tick the block SHALL apply y-=4, saturating at 0; on reaching 0 it SHALL pulse escaped and enter IDLE.
REQ-021 Shots SHALL be ignored in HIT, FALL and ESCAPE.
REQ-022 Animation: a 2-bit flap counter SHALL advance every 8 frame ticks in FLY and ESCAPE, cycling 0,1,2,0.
REQ-023 Sprite frame SHALL be: the flap value in FLY/ESCAPE, 3 in HIT, 4 in FALL.
REQ-024 is_duck SHALL be combinational, asserted when state!=IDLE and x<=DrawX<=x+63 and y<=DrawY<=y+63.
REQ-025 With offsets ox=DrawX-x and oy=DrawY-y, duck_addr SHALL be frame*4096 + oy*64 + (vx<0 ? 63-ox : ox), and 0 when is_duck is low.
REQ-026 hit and escaped SHALL each be exactly one Clk cycle wide.

Reset
REQ-027 On Reset low, regardless of Clk, the block SHALL set: state=IDLE, x=0, y=GROUND_Y, vx=+SPEED, vy=-SPEED, shots_left=0, all counters 0, all synchronizer flops 0, hit=0, escaped=0.
REQ-028 Reset asserted mid-flight SHALL abort to IDLE with no hit or escaped pulse.

Configuration
REQ-029 With DUCK_JITTER_EN defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to the seed) SHALL step every Clk.
REQ-030 With DUCK_JITTER_EN defined, on each X-bound bounce vy's sign SHALL be set from LFSR bit 0 (1 = negative).
REQ-031 Without DUCK_JITTER_EN, no LFSR SHALL exist and vy SHALL change only on Y-bound bounces.

Verification
REQ-032 Reset low mid-FLY -> state=0, shots_left=0, is_duck=0 immediately, without waiting for a Clk edge.
REQ-033 launch, then 10 frame ticks -> x=20, y=332, duck_state=1.
REQ-034 After launch, cursor=(30,360), shot after 5 ticks (duck at 10,342) -> hit pulse, shots_left=2, state HIT; 30 ticks later FALL; then IDLE once y=352.
REQ-035 Three missed shots (cursor 639,0) -> shots_left=0, ESCAPE, one escaped pulse once y=0, then IDLE; a fourth shot has no effect.
REQ-036 Duck at x=574, vx=+2, one tick -> x=575, vx=-2; DrawX=575,DrawY=y in FLY flap 0 -> duck_addr=63.
REQ-037 Shot and frame tick in the same cycle with the cursor inside the pre-update box only -> hit asserted, position unchanged.
